// File: rtl/iob_wishbone_master_if.sv
// Wishbone B4 pipelined bus bundle between the IOb bridge (master) and its peripherals (slave).
interface iob_wishbone_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int WADR_W = ADDR_W - $clog2(DATA_W / 8);

  logic [WADR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_we_o;
  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;
  logic                wb_stall_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
  );
endinterface

// File: rtl/iob_wishbone_master.sv
// IOb native bus to Wishbone B4 pipelined master: small request FIFO, one transfer
// in flight, per-transfer timeout and sticky error reporting. All outputs registered.
module iob_wishbone_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_DEPTH = 2,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                valid_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                req_ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ready_o,
  output logic                err_o,
  output logic                err_sticky_o,
  input  logic                clr_err_i,
  iob_wishbone_master_if.master wb
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WADR_W = ADDR_W - OFF_W;
  localparam int ENT_W  = WADR_W + DATA_W + STRB_W;
  localparam int PTR_W  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W  = $clog2(REQ_DEPTH + 1);
  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(REQ_DEPTH - 1);
  localparam logic [CNT_W-1:0]     DEPTH_C  = CNT_W'(REQ_DEPTH);
  // Timeout fires one cycle before the counter would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t              state_r, state_nxt_s;
  logic [ENT_W-1:0]    mem_r [REQ_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_nxt_s;
  logic [TIMEOUT_W-1:0] tmo_cnt_r;
  logic                push_s, pop_s, drop_s, tmo_s, resp_err_s, rd_ack_s;
  logic [ENT_W-1:0]    head_s;
  logic [WADR_W-1:0]   head_adr_s;
  logic [DATA_W-1:0]   head_dat_s;
  logic [STRB_W-1:0]   head_strb_s;
  logic                req_ready_r, ready_r, err_r, err_sticky_r;
  logic [DATA_W-1:0]   rdata_r, wb_dat_r;
  logic [WADR_W-1:0]   wb_adr_r;
  logic [STRB_W-1:0]   wb_sel_r;
  logic                wb_we_r, wb_cyc_r, wb_stb_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return PTR_W'(0);
    else return p + PTR_W'(1);
  endfunction

  generate
    if (OFF_W > 0) begin : g_byte_off
      logic unused_addr_s;
      assign unused_addr_s = ^address_i[OFF_W-1:0];
    end
  endgenerate

  assign push_s = valid_i & req_ready_r;
  assign drop_s = valid_i & ~req_ready_r;
  // An empty FIFO forwards the incoming request so IDLE can launch it immediately.
  assign head_s = (count_r == CNT_W'(0)) ? {address_i[ADDR_W-1:OFF_W], wdata_i, wstrb_i}
                                         : mem_r[rd_ptr_r];
  assign {head_adr_s, head_dat_s, head_strb_s} = head_s;
  assign pop_s  = (state_r == IDLE) && ((count_r != CNT_W'(0)) || push_s);
  assign tmo_s  = (tmo_cnt_r == TMO_LAST);

  assign req_ready_o  = req_ready_r;
  assign rdata_o      = rdata_r;
  assign ready_o      = ready_r;
  assign err_o        = err_r;
  assign err_sticky_o = err_sticky_r;
  assign wb.wb_adr_o  = wb_adr_r;
  assign wb.wb_dat_o  = wb_dat_r;
  assign wb.wb_sel_o  = wb_sel_r;
  assign wb.wb_we_o   = wb_we_r;
  assign wb.wb_cyc_o  = wb_cyc_r;
  assign wb.wb_stb_o  = wb_stb_r;

  // FIFO occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Transfer sequencing; err beats ack, and a real response beats the timeout
  always_comb begin
    state_nxt_s = state_r;
    resp_err_s  = 1'b0;
    rd_ack_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pop_s) state_nxt_s = REQ;
        else       state_nxt_s = IDLE;
      end
      REQ: begin
        if (!wb.wb_stall_i && (wb.wb_ack_i || wb.wb_err_i)) begin
          state_nxt_s = RESP;
          resp_err_s  = wb.wb_err_i;
          rd_ack_s    = wb.wb_ack_i & ~wb.wb_err_i & ~wb_we_r;
        end else if (tmo_s) begin
          state_nxt_s = RESP;
          resp_err_s  = 1'b1;
        end else if (!wb.wb_stall_i) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (wb.wb_ack_i || wb.wb_err_i) begin
          state_nxt_s = RESP;
          resp_err_s  = wb.wb_err_i;
          rd_ack_s    = wb.wb_ack_i & ~wb.wb_err_i & ~wb_we_r;
        end else if (tmo_s) begin
          state_nxt_s = RESP;
          resp_err_s  = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_r <= IDLE;
    else           state_r <= state_nxt_s;
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_s) mem_r[wr_ptr_r] <= {address_i[ADDR_W-1:OFF_W], wdata_i, wstrb_i};
  end

  // FIFO pointers, occupancy and registered not-full flag
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_r    <= PTR_W'(0);
      rd_ptr_r    <= PTR_W'(0);
      count_r     <= CNT_W'(0);
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r     <= count_nxt_s;
      req_ready_r <= (count_nxt_s != DEPTH_C);
    end
  end

  // Per-transfer timeout counter
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                             tmo_cnt_r <= TIMEOUT_W'(0);
    else if (pop_s)                            tmo_cnt_r <= TIMEOUT_W'(0);
    else if (state_r == REQ || state_r == WAIT) tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
  end

  // Wishbone request registers and IOb response registers
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wb_adr_r <= WADR_W'(0);
      wb_dat_r <= DATA_W'(0);
      wb_sel_r <= STRB_W'(0);
      wb_we_r  <= 1'b0;
      wb_cyc_r <= 1'b0;
      wb_stb_r <= 1'b0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= DATA_W'(0);
    end else begin
      wb_cyc_r <= (state_nxt_s == REQ) || (state_nxt_s == WAIT);
      wb_stb_r <= (state_nxt_s == REQ);
      ready_r  <= (state_nxt_s == RESP);
      err_r    <= (state_nxt_s == RESP) && resp_err_s;
      if (pop_s) begin
        wb_adr_r <= head_adr_s;
        wb_dat_r <= head_dat_s;
        wb_we_r  <= (head_strb_s != STRB_W'(0));
        wb_sel_r <= (head_strb_s != STRB_W'(0)) ? head_strb_s : {STRB_W{1'b1}};
      end
      if (state_nxt_s == RESP) rdata_r <= rd_ack_s ? wb.wb_dat_i : DATA_W'(0);
    end
  end

  // Sticky error: a new error or dropped request outranks a clear
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                                        err_sticky_r <= 1'b0;
    else if (drop_s || (state_nxt_s == RESP && resp_err_s)) err_sticky_r <= 1'b1;
    else if (clr_err_i)                                   err_sticky_r <= 1'b0;
  end
endmodule

// File: tb/tb_iob_wishbone_master.sv
// Directed and randomized checks of iob_wishbone_master against a reactive Wishbone
// slave model and a queue-based response model.
module tb_iob_wishbone_master;
  localparam int ADDR_W = 32, DATA_W = 32, REQ_DEPTH = 2, TIMEOUT_W = 4;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        valid_i = 1'b0, clr_err_i = 1'b0;
  logic [31:0] address_i = 32'd0, wdata_i = 32'd0;
  logic [3:0]  wstrb_i = 4'd0;
  logic        req_ready_o, ready_o, err_o, err_sticky_o;
  logic [31:0] rdata_o;

  always #5 clk_i = ~clk_i;

  iob_wishbone_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

  iob_wishbone_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_DEPTH(REQ_DEPTH),
                        .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .valid_i(valid_i), .address_i(address_i),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .req_ready_o(req_ready_o), .rdata_o(rdata_o),
    .ready_o(ready_o), .err_o(err_o), .err_sticky_o(err_sticky_o), .clr_err_i(clr_err_i),
    .wb(wb)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid_i = 1'b1; address_i = a; wdata_i = d; wstrb_i = s;
  endtask

  // Slave model: stalls, then answers after a latency in the cycles following acceptance
  logic [31:0] slave_mem [64];
  int  slave_stall = 0, slave_lat = 0, s_st, s_lt;
  bit  slave_mute = 1'b0, slave_rand = 1'b0, slave_force_err = 1'b0, slave_both = 1'b0;
  bit  slave_addr_err = 1'b0, s_err, s_both;

  initial begin
    wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_stall_i = 1'b0; wb.wb_dat_i = 32'd0;
    forever begin
      @(negedge clk_i);
      wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_stall_i = 1'b0; wb.wb_dat_i = 32'd0;
      if (wb.wb_cyc_o && wb.wb_stb_o && !slave_mute) begin
        s_st   = slave_rand ? int'($urandom_range(3, 0)) : slave_stall;
        s_lt   = slave_rand ? int'($urandom_range(4, 0)) : slave_lat;
        s_err  = slave_force_err || (slave_addr_err && wb.wb_adr_o[2:0] == 3'd7);
        s_both = slave_both || (slave_addr_err && wb.wb_adr_o[3]);
        for (int n = 0; n < s_st; n++) begin
          wb.wb_stall_i = 1'b1;
          @(negedge clk_i);
        end
        wb.wb_stall_i = 1'b0;
        @(negedge clk_i);
        repeat (s_lt) @(negedge clk_i);
        wb.wb_err_i = s_err;
        wb.wb_ack_i = !s_err || s_both;
        wb.wb_dat_i = slave_mem[wb.wb_adr_o[5:0]];
      end
    end
  end

  // Reference model: each accepted request yields one response, in order
  typedef struct packed {
    logic [29:0] adr; logic [31:0] dat; logic [3:0] sel; logic we;
    logic [31:0] rdata; logic err;
  } exp_t;
  exp_t exp_q[$];
  bit   exp_sticky = 1'b0, pend_clr = 1'b0;

  task automatic rnd_cycle(input bit allow_new);
    exp_t e;
    bit   got_err;
    got_err = 1'b0;
    if (ready_o === 1'b1) begin
      if (exp_q.size() == 0) chk("rnd_unexpected_ready", ready_o, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("rnd_rdata", rdata_o, e.rdata);
        chk("rnd_err", err_o, e.err);
        chk("rnd_adr", wb.wb_adr_o, e.adr);
        chk("rnd_sel", wb.wb_sel_o, e.sel);
        chk("rnd_we", wb.wb_we_o, e.we);
        if (e.we) chk("rnd_dat", wb.wb_dat_o, e.dat);
        got_err = e.err;
      end
    end else begin
      chk("rnd_err_idle", err_o, 1'b0);
    end
    if (got_err) exp_sticky = 1'b1;
    else if (pend_clr) exp_sticky = 1'b0;
    chk("rnd_sticky", err_sticky_o, exp_sticky);
    pend_clr  = allow_new && ($urandom_range(19, 0) == 0);
    clr_err_i = pend_clr;
    if (allow_new && req_ready_o && $urandom_range(9, 0) < 4) begin
      address_i = $urandom;
      wdata_i   = $urandom;
      wstrb_i   = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
      valid_i   = 1'b1;
      e.adr   = address_i[31:2];
      e.dat   = wdata_i;
      e.we    = (wstrb_i != 4'd0);
      e.sel   = e.we ? wstrb_i : 4'hF;
      e.err   = (e.adr[2:0] == 3'd7);
      e.rdata = (e.we || e.err) ? 32'd0 : slave_mem[e.adr[5:0]];
      exp_q.push_back(e);
    end else begin
      valid_i = 1'b0;
    end
    step();
  endtask

  int n, rcnt, rcyc[3];
  logic [31:0] rdat[3];

  initial begin
    for (int i = 0; i < 64; i++) slave_mem[i] = $urandom;
    slave_mem[6'h01] = 32'hDEADBEEF;

    // Reset values
    step(); step();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_sticky", err_sticky_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_cyc_stb", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 3'b000);
    chk("rst_adr_sel", {wb.wb_adr_o, wb.wb_sel_o}, 34'd0);
    arst_n_i = 1'b1;
    step();

    // Single read, zero-wait slave
    drive(32'h104, 32'd0, 4'd0); step(); valid_i = 1'b0;
    chk("rd_stb_c1", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b11);
    chk("rd_adr", wb.wb_adr_o, 30'h41);
    chk("rd_sel", wb.wb_sel_o, 4'hF);
    chk("rd_we", wb.wb_we_o, 1'b0);
    step();
    chk("rd_wait_c2", {wb.wb_cyc_o, wb.wb_stb_o, ready_o}, 3'b100);
    step();
    chk("rd_ready_c3", ready_o, 1'b1);
    chk("rd_rdata", rdata_o, 32'hDEADBEEF);
    chk("rd_err", err_o, 1'b0);
    chk("rd_cyc_c3", wb.wb_cyc_o, 1'b0);
    step();
    chk("rd_ready_pulse", ready_o, 1'b0);
    chk("rd_rdata_hold", rdata_o, 32'hDEADBEEF);
    step(); step();

    // Write with 3 stall cycles
    slave_stall = 3;
    drive(32'h200, 32'h1234, 4'h3); step(); valid_i = 1'b0;
    n = 0;
    while (wb.wb_stb_o === 1'b1 && n < 20) begin
      n++;
      step();
    end
    chk("wr_stb_len", n, 4);
    chk("wr_wait_no_ready", {wb.wb_cyc_o, ready_o}, 2'b10);
    step();
    chk("wr_ready", ready_o, 1'b1);
    chk("wr_rdata_zero", rdata_o, 32'd0);
    chk("wr_sel_we_dat", {wb.wb_sel_o, wb.wb_we_o, wb.wb_dat_o}, {4'h3, 1'b1, 32'h1234});
    slave_stall = 0;
    step(); step(); step();

    // FIFO fill against a slow slave; the 4th request is dropped
    slave_lat = 3;
    for (int i = 0; i < 4; i++) begin
      chk("fill_req_ready", req_ready_o, (i < 3) ? 1'b1 : 1'b0);
      drive(32'h40 + 32'(i * 4), 32'd0, 4'd0);
      step();
    end
    valid_i = 1'b0;
    chk("fill_drop_sticky", err_sticky_o, 1'b1);
    rcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (ready_o === 1'b1) begin
        if (rcnt < 3) begin rcyc[rcnt] = c; rdat[rcnt] = rdata_o; end
        rcnt++;
      end
      step();
    end
    chk("fill_ready_count", rcnt, 3);
    chk("fill_order0", rdat[0], slave_mem[6'h10]);
    chk("fill_order1", rdat[1], slave_mem[6'h11]);
    chk("fill_order2", rdat[2], slave_mem[6'h12]);
    chk("fill_b2b_gap", rcyc[2] - rcyc[1], 7);
    clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
    chk("fill_clr_sticky", err_sticky_o, 1'b0);
    slave_lat = 0;

    // Bus error with simultaneous ack
    slave_lat = 1; slave_force_err = 1'b1; slave_both = 1'b1;
    drive(32'h8, 32'd0, 4'd0); step(); valid_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (ready_o === 1'b1) break;
      step();
    end
    chk("berr_ready", ready_o, 1'b1);
    chk("berr_err", err_o, 1'b1);
    chk("berr_rdata", rdata_o, 32'd0);
    chk("berr_sticky", err_sticky_o, 1'b1);
    step();
    chk("berr_err_pulse", err_o, 1'b0);
    clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
    chk("berr_clr", err_sticky_o, 1'b0);
    slave_lat = 0; slave_force_err = 1'b0; slave_both = 1'b0;
    step();

    // Timeout: silent slave
    slave_mute = 1'b1;
    drive(32'h400, 32'd0, 4'd0); step(); valid_i = 1'b0;
    chk("tmo_entry_stb", wb.wb_stb_o, 1'b1);
    n = 0;
    while (wb.wb_cyc_o === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("tmo_cyc_len", n, 15);
    chk("tmo_ready_err", {ready_o, err_o}, 2'b11);
    chk("tmo_rdata", rdata_o, 32'd0);
    step(); step();

    // Reset in WAIT with two requests queued
    drive(32'h500, 32'd0, 4'd0); step();
    drive(32'h504, 32'd0, 4'd0); step();
    drive(32'h508, 32'd0, 4'd0); step(); valid_i = 1'b0;
    chk("arst_in_wait", {wb.wb_cyc_o, wb.wb_stb_o, req_ready_o}, 3'b100);
    #2 arst_n_i = 1'b0;
    #1 chk("arst_async_drop", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b00);
    @(negedge clk_i) arst_n_i = 1'b1;
    slave_mute = 1'b0;
    chk("arst_req_ready", req_ready_o, 1'b1);
    chk("arst_sticky", err_sticky_o, 1'b0);
    rcnt = 0; n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ready_o === 1'b1) rcnt++;
      if (wb.wb_cyc_o === 1'b1) n++;
    end
    chk("arst_no_ready", rcnt, 0);
    chk("arst_fifo_discarded", n, 0);

    // Randomized traffic against the reference model
    slave_rand = 1'b1; slave_addr_err = 1'b1;
    exp_sticky = 1'b0; pend_clr = 1'b0;
    for (int c = 0; c < 800; c++) rnd_cycle(1'b1);
    valid_i = 1'b0; clr_err_i = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) rnd_cycle(1'b0);
    chk("rnd_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
